// File: rtl/jtkiwi_shrarb_if.sv
// CPU-side bus of the shared-RAM arbiter: one instance per requesting CPU.
// stall is the CPU wait request; "wait" itself is a reserved word.
interface jtkiwi_shrarb_if #(
    parameter int AW = 13
);
    logic          cs;
    logic          rnw;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          stall;

    modport master (
        output cs, rnw, addr, din,
        input  dout, stall
    );

    modport slave (
        input  cs, rnw, addr, din,
        output dout, stall
    );
endinterface

// File: rtl/jtkiwi_shrarb.sv
// Serialises main and sub CPU bus cycles onto one synchronous 8-bit RAM port,
// one RAM access per bus cycle, round-robin on simultaneous requests.
module jtkiwi_shrarb #(
    parameter int AW = 13
) (
    input  logic              rst,
    input  logic              clk,
    jtkiwi_shrarb_if.slave    m,
    jtkiwi_shrarb_if.slave    s,
    output logic [AW-1:0]     ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout
);
    typedef enum logic [1:0] {IDLE, ACC, LAT} state_t;

    state_t state;
    logic   gnt;        // 1: sub owns the current access
    logic   last;       // 1: sub was granted most recently
    logic   gnt_rd;
    logic   done_m;
    logic   done_s;

    logic   pend_m;
    logic   pend_s;
    logic   pick_s;

    assign pend_m  = m.cs & ~done_m;
    assign pend_s  = s.cs & ~done_s;
    assign m.stall = pend_m;
    assign s.stall = pend_s;

    // On a tie the requester that was not served last wins
    assign pick_s = pend_s & (~pend_m | ~last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last     <= 1'b1;
            gnt_rd   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            m.dout   <= 8'h00;
            s.dout   <= 8'h00;
            done_m   <= 1'b0;
            done_s   <= 1'b0;
        end else begin
            if (!m.cs) done_m <= 1'b0;
            if (!s.cs) done_s <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_m || pend_s) begin
                        state <= ACC;
                        gnt   <= pick_s;
                        last  <= pick_s;
                        if (pick_s) begin
                            ram_addr <= s.addr;
                            ram_din  <= s.din;
                            ram_we   <= ~s.rnw;
                            gnt_rd   <= s.rnw;
                        end else begin
                            ram_addr <= m.addr;
                            ram_din  <= m.din;
                            ram_we   <= ~m.rnw;
                            gnt_rd   <= m.rnw;
                        end
                    end
                end
                ACC: begin
                    ram_we <= 1'b0;
                    state  <= LAT;
                end
                LAT: begin
                    state <= IDLE;
                    // done only sticks if the CPU is still in the same bus cycle
                    if (gnt) begin
                        if (gnt_rd) s.dout <= ram_dout;
                        done_s <= s.cs;
                    end else begin
                        if (gnt_rd) m.dout <= ram_dout;
                        done_m <= m.cs;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtkiwi_shrarb.sv
// Vector table plus hand-written corner sequences for the shared-RAM arbiter,
// with a behavioural synchronous RAM and per-CPU read-data scoreboards.
module tb_jtkiwi_shrarb;
    localparam int AW = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtkiwi_shrarb_if #(.AW(AW)) m_bus ();
    jtkiwi_shrarb_if #(.AW(AW)) s_bus ();

    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;

    jtkiwi_shrarb #(.AW(AW)) dut (
        .rst      (rst),
        .clk      (clk),
        .m        (m_bus),
        .s        (s_bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    // Synchronous RAM model with a bench-side preload path
    logic [7:0]    mem [0:(1<<AW)-1] = '{default: 8'h00};
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [7:0]    pl_data = 8'h00;

    always @(posedge clk) begin
        if (pl_we)       mem[pl_addr]  <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int            we_total = 0;
    logic [AW-1:0] we_addr;
    logic [7:0]    we_din;
    always @(negedge clk) begin
        if (ram_we) begin
            we_total <= we_total + 1;
            we_addr  <= ram_addr;
            we_din   <= ram_din;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_s[$];

    typedef struct {
        bit            m_en;
        bit            m_rnw;
        logic [AW-1:0] m_addr;
        logic [7:0]    m_din;
        logic [7:0]    m_exp;
        int            m_wait;
        bit            s_en;
        bit            s_rnw;
        logic [AW-1:0] s_addr;
        logic [7:0]    s_din;
        logic [7:0]    s_exp;
        int            s_wait;
        int            n_we;
        logic [AW-1:0] we_a;
        logic [7:0]    we_d;
        int            hold;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Counts wait cycles per side and checks dout when each wait falls
    task automatic measure(input bit m_en, input bit s_en, input int exp_mw,
                           input int exp_sw, input int hold, input string tag);
        int mw = 0;
        int sw = 0;
        bit mf = !m_en;
        bit sf = !s_en;
        for (int c = 0; c < 20 && !(mf && sf); c++) begin
            @(negedge clk);
            if (!mf) begin
                if (m_bus.stall) mw++;
                else begin mf = 1'b1; chk({tag, " m_dout"}, 32'(m_bus.dout), 32'(q_m.pop_front())); end
            end
            if (!sf) begin
                if (s_bus.stall) sw++;
                else begin sf = 1'b1; chk({tag, " s_dout"}, 32'(s_bus.dout), 32'(q_s.pop_front())); end
            end
        end
        if (!mf) begin errors++; checks++; $display("FAIL %s m_wait timeout actual=1 required=0", tag); end
        if (!sf) begin errors++; checks++; $display("FAIL %s s_wait timeout actual=1 required=0", tag); end
        if (m_en) chk({tag, " m_wait_cycles"}, 32'(mw), 32'(exp_mw));
        if (s_en) chk({tag, " s_wait_cycles"}, 32'(sw), 32'(exp_sw));
        repeat (hold) @(negedge clk);
    endtask

    task automatic release_cs();
        @(posedge clk); #1;
        m_bus.cs = 1'b0;
        s_bus.cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   we0;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("vec%0d", idx);
        we0 = we_total;
        if (v.m_en) q_m.push_back(v.m_exp);
        if (v.s_en) q_s.push_back(v.s_exp);
        @(posedge clk); #1;
        m_bus.cs = v.m_en; m_bus.rnw = v.m_rnw; m_bus.addr = v.m_addr; m_bus.din = v.m_din;
        s_bus.cs = v.s_en; s_bus.rnw = v.s_rnw; s_bus.addr = v.s_addr; s_bus.din = v.s_din;
        measure(v.m_en, v.s_en, v.m_wait, v.s_wait, v.hold, tag);
        chk({tag, " we_pulses"}, 32'(we_total - we0), 32'(v.n_we));
        if (v.n_we == 1) begin
            chk({tag, " we_addr"}, 32'(we_addr), 32'(v.we_a));
            chk({tag, " we_din"}, 32'(we_din), 32'(v.we_d));
        end
        $display("txn %s m(en=%0d rnw=%0d a=%h) s(en=%0d rnw=%0d a=%h) m_dout=%h s_dout=%h",
                 tag, v.m_en, v.m_rnw, v.m_addr, v.s_en, v.s_rnw, v.s_addr,
                 m_bus.dout, s_bus.dout);
        release_cs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        //        m_en rnw addr     din    exp    mw  s_en rnw addr     din    exp    sw  nwe we_a     we_d   hold
        vecs[0] = '{1, 1, 13'h0123, 8'h00, 8'hA5, 3,  0, 1, 13'h0000, 8'h00, 8'h00, 0,  0, 13'h0000, 8'h00, 0};
        vecs[1] = '{1, 0, 13'h1FFF, 8'h3C, 8'hA5, 3,  0, 1, 13'h0000, 8'h00, 8'h00, 0,  1, 13'h1FFF, 8'h3C, 20};
        vecs[2] = '{0, 1, 13'h0000, 8'h00, 8'h00, 0,  1, 1, 13'h1FFF, 8'h00, 8'h3C, 3,  0, 13'h0000, 8'h00, 0};
        vecs[3] = '{1, 1, 13'h0010, 8'h00, 8'h5A, 3,  1, 0, 13'h0020, 8'h77, 8'h3C, 6,  1, 13'h0020, 8'h77, 0};
        vecs[4] = '{1, 1, 13'h0020, 8'h00, 8'h77, 3,  0, 1, 13'h0000, 8'h00, 8'h00, 0,  0, 13'h0000, 8'h00, 0};
        vecs[5] = '{1, 0, 13'h0030, 8'h11, 8'h77, 6,  1, 1, 13'h0010, 8'h00, 8'h5A, 3,  1, 13'h0030, 8'h11, 0};
        vecs[6] = '{1, 1, 13'h0030, 8'h00, 8'h11, 6,  1, 1, 13'h0123, 8'h00, 8'hA5, 3,  0, 13'h0000, 8'h00, 0};

        rst = 1'b1;
        m_bus.cs = 1'b0; m_bus.rnw = 1'b1; m_bus.addr = '0; m_bus.din = 8'h00;
        s_bus.cs = 1'b0; s_bus.rnw = 1'b1; s_bus.addr = '0; s_bus.din = 8'h00;
        preload(13'h0123, 8'hA5);
        preload(13'h0010, 8'h5A);

        @(negedge clk);
        chk("rst ram_we", 32'(ram_we), 0);
        chk("rst ram_addr", 32'(ram_addr), 0);
        chk("rst ram_din", 32'(ram_din), 0);
        chk("rst m_dout", 32'(m_bus.dout), 0);
        chk("rst s_dout", 32'(s_bus.dout), 0);
        chk("rst m_wait", 32'(m_bus.stall), 0);
        m_bus.cs = 1'b1; #1;
        chk("rst m_wait follows cs", 32'(m_bus.stall), 1);
        m_bus.cs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Sub write with cs removed during ACC: the write lands, done stays clear
        we0 = we_total;
        @(posedge clk); #1;
        s_bus.cs = 1'b1; s_bus.rnw = 1'b0; s_bus.addr = 13'h0555; s_bus.din = 8'h99;
        @(posedge clk); #1;
        s_bus.cs = 1'b0;
        @(negedge clk);
        chk("drop ram_we in ACC", 32'(ram_we), 1);
        chk("drop ram_addr", 32'(ram_addr), 32'h0555);
        chk("drop ram_din", 32'(ram_din), 32'h99);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("drop mem written", 32'(mem[13'h0555]), 32'h99);
        chk("drop we_pulses", 32'(we_total - we0), 1);
        q_s.push_back(8'h99);
        @(posedge clk); #1;
        s_bus.cs = 1'b1; s_bus.rnw = 1'b1; s_bus.addr = 13'h0555;
        measure(1'b0, 1'b1, 0, 3, 0, "drop refetch");
        $display("txn drop-cs sub write 0555 then refetch s_dout=%h", s_bus.dout);
        release_cs();

        // Reset asserted during the ACC cycle of a main write
        @(posedge clk); #1;
        m_bus.cs = 1'b1; m_bus.rnw = 1'b0; m_bus.addr = 13'h0AAA; m_bus.din = 8'h42;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid ram_we before", 32'(ram_we), 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid ram_we", 32'(ram_we), 0);
        chk("rstmid ram_addr", 32'(ram_addr), 0);
        chk("rstmid ram_din", 32'(ram_din), 0);
        chk("rstmid m_dout", 32'(m_bus.dout), 0);
        chk("rstmid s_dout", 32'(s_bus.dout), 0);
        chk("rstmid m_wait follows cs", 32'(m_bus.stall), 1);
        m_bus.rnw = 1'b1; m_bus.addr = 13'h0010;
        s_bus.cs = 1'b1; s_bus.rnw = 1'b1; s_bus.addr = 13'h0123;
        q_m.push_back(8'h5A);
        q_s.push_back(8'hA5);
        @(posedge clk); #1;
        rst = 1'b0;
        measure(1'b1, 1'b1, 3, 6, 0, "rstmid tie");
        chk("rstmid no write", 32'(mem[13'h0AAA]), 0);
        $display("txn reset-mid-access then tie m_dout=%h s_dout=%h", m_bus.dout, s_bus.dout);
        release_cs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtkiwi_shrarb.md
# jtkiwi_shrarb

Arbiter for the single-port 8 kB shared RAM between the Kiwi main CPU and the sub/sound CPU. It replaces dual-port access with one synchronous RAM port. Each CPU bus cycle is serialised into exactly one RAM access, and each requester is stalled through a wait line until its data is ready. The block sits between the main and sub CPU wrappers and the shared RAM instance inside the game top.

## Interface
- `AW`, 13, shared RAM address width.
- `rst`  in  1  asynchronous reset, active-high.
- `clk`  in  1  system clock (24 MHz). Single clock domain.
- `m_cs`  in  1  main CPU selects shared RAM; held for the whole bus cycle.
- `m_rnw`  in  1  main read (1) / write (0).
- `m_addr`  in  AW  main address.
- `m_din`  in  8  main write data.
- `m_dout`  out  8  main read data; holds until the next main read completes.
- `m_wait`  out  1  main stall request.
- `s_cs`, `s_rnw`, `s_addr`, `s_din`, `s_dout`, `s_wait`: same as the main-side ports, for the sub CPU.
- `ram_addr`  out  AW  RAM address (registered).
- `ram_din`  out  8  RAM write data (registered).
- `ram_we`  out  1  RAM write strobe (registered), one cycle per write.
- `ram_dout`  in  8  RAM read data. Synchronous RAM: valid one cycle after `ram_addr`.

## Operation
- Per requester x ∈ {m,s}: `done_x` flag. `pend_x = x_cs & ~done_x`. `x_wait = pend_x`, combinational, so it rises in the same cycle as `x_cs`.
- FSM states:
  - IDLE → ACC when any `pend_x` is high at the edge.
  - ACC → LAT unconditionally.
  - LAT → IDLE unconditionally.
- Grant on the IDLE→ACC edge:
  - Only one pending: grant it.
  - Both pending: grant the one that is not `last`. `last` resets to sub, so main wins the first tie.
- Grant edge registers:
  - `gnt`
  - `ram_addr` from `x_addr`
  - `ram_din` from `x_din`
  - `ram_we` = `~x_rnw`
  - `last` = x
- Address and data changes after the grant edge are ignored.
- ACC→LAT edge: `ram_we` ← 0.
- LAT→IDLE edge:
  - If the granted access was a read, `x_dout` ← `ram_dout`. `x_dout` is not touched on writes.
  - `done_x` ← `x_cs`.
- `done_x` clears at any edge where `x_cs` is sampled low. A CPU must drop cs for at least one edge before its next access, which guarantees exactly one RAM access per bus cycle.
- cs dropped while granted (ACC or LAT):
  - The access completes.
  - A write still occurs.
  - `done_x` is not set.
- Reset values: state IDLE, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `m_dout`=`s_dout`=0, `done_m`=`done_s`=0, `last`=sub. `x_wait` follows `x_cs` during reset.
- Reset asserted mid-access: the access aborts immediately and `ram_we` drops asynchronously. No data is latched.

## Timing
- Uncontended access, with cs high from cycle 0:
  - Grant at the end of cycle 0.
  - Cycle 1: ACC. `ram_addr`/`ram_we` are valid.
  - Cycle 2: LAT. `ram_dout` is valid.
  - `x_dout` is valid and `x_wait`=0 from cycle 3.
- Wait is asserted for exactly 3 cycles.
- Contended access: the loser is granted at the edge ending its IDLE cycle, after the winner's LAT, so its wait lasts 6 cycles.
- Peak throughput is one access per 3 clocks. No back-to-back grants without an IDLE cycle.
- `ram_we` is high for exactly one cycle (ACC) per write. It is never high in IDLE or LAT.

## Test plan
- Main read only: preload RAM[0x0123]=0xA5, hold `m_cs`=1, `m_rnw`=1.
  - Required: `m_wait` high for 3 cycles.
  - Required: `m_dout`=0xA5 at cycle 3.
  - Required: no `ram_we`.
- Main write only: write 0x3C to 0x1FFF.
  - Required: a single `ram_we` pulse with `ram_addr`=0x1FFF, `ram_din`=0x3C.
  - Required: holding cs for 20 more cycles yields no second pulse.
- Simultaneous requests: main reads 0x0010 and sub writes 0x0020 in the same cycle.
  - Required: main is granted first, with wait=3.
  - Required: sub is granted next, with wait=6.
  - Repeat the tie: sub is granted first (round-robin).
- cs dropped in ACC: sub write with `s_cs` removed during ACC.
  - Required: the write still lands.
  - Required: `done_s` stays 0.
  - Required: the next `s_cs` triggers a fresh access.
- Reset mid-access: assert `rst` during the ACC of a write.
  - Required: `ram_we` is 0 immediately.
  - Required: all outputs return to reset values.
  - Required: a pending cs after reset is served normally, main first on a tie.
